// File: rtl/logic_sweep_pkg.sv
// Shared mode encodings and FSM state type for the truth-table sweeper.
// Pure declarations; no logic, no latency, no flow control.
package logic_sweep_pkg;

    localparam logic [2:0] MODE_NOR  = 3'b000;
    localparam logic [2:0] MODE_NAND = 3'b001;
    localparam logic [2:0] MODE_AND  = 3'b010;
    localparam logic [2:0] MODE_OR   = 3'b011;
    localparam logic [2:0] MODE_XOR  = 3'b100;
    localparam logic [2:0] MODE_XNOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logic_sweep_eval.sv
// Combinational gate evaluator: reduces vec through the gate chosen by mode.
// Zero latency, no backpressure; reserved modes evaluate to 0.
module logic_eval
    import logic_sweep_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] vec,
    output logic             s
);

    always_comb begin
        s = 1'b0;
        case (mode)
            MODE_NOR:  s = ~(|vec);
            MODE_NAND: s = ~(&vec);
            MODE_AND:  s = &vec;
            MODE_OR:   s = |vec;
            MODE_XOR:  s = ^vec;
            MODE_XNOR: s = ~(^vec);
            default:   s = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_sweep.sv
// Sweeps all 2^WIDTH input rows through one gate, one row per cycle, counting ones.
// First row 1 cycle after start; optional LOGIC_SWEEP_HOLD_EN adds a hold input that stalls RUN.
module logic_sweep
    import logic_sweep_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
`ifdef LOGIC_SWEEP_HOLD_EN
    input  logic             hold,
`endif
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] vec,
    output logic             s,
    output logic [WIDTH:0]   ones_cnt,
    output logic             done
);

    localparam logic [WIDTH-1:0] LAST_ROW = '1;

    state_t           state;
    logic [2:0]       mode_q;
    logic             hold_eff;
    logic [2:0]       eval_mode;
    logic [WIDTH-1:0] eval_vec;
    logic             s_next;

`ifdef LOGIC_SWEEP_HOLD_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    // The evaluator always looks one row ahead so s lands in the same register stage as vec.
    assign eval_mode = (state == ST_IDLE) ? mode : mode_q;
    assign eval_vec  = (state == ST_IDLE) ? '0 : vec + WIDTH'(1);

    logic_eval #(.WIDTH(WIDTH)) u_eval (
        .mode (eval_mode),
        .vec  (eval_vec),
        .s    (s_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_NOR;
            busy     <= 1'b0;
            valid    <= 1'b0;
            done     <= 1'b0;
            s        <= 1'b0;
            vec      <= '0;
            ones_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= ST_RUN;
                        mode_q   <= mode;
                        busy     <= 1'b1;
                        valid    <= 1'b1;
                        vec      <= '0;
                        s        <= s_next;
                        ones_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // A row is counted once, on the edge after it was shown with valid set.
                    ones_cnt <= ones_cnt + (WIDTH+1)'(valid & s);
                    if (hold_eff) begin
                        valid <= 1'b0;
                    end else if (vec == LAST_ROW) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec   <= eval_vec;
                        s     <= s_next;
                        valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep.sv
// Scoreboard bench: three sweepers (WIDTH 1, 2, 3) share stimulus; a truth-table model predicts rows.
// Monitor pops predictions on every valid row or done pulse, independent of the stimulus thread.
module tb_logic_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] mode  = 3'b000;
`ifdef LOGIC_SWEEP_HOLD_EN
    logic       hold  = 1'b0;
`endif

    logic       busy_a, valid_a, s_a, done_a;
    logic [0:0] vec_a;
    logic [1:0] ones_a;
    logic       busy_b, valid_b, s_b, done_b;
    logic [1:0] vec_b;
    logic [2:0] ones_b;
    logic       busy_c, valid_c, s_c, done_c;
    logic [2:0] vec_c;
    logic [3:0] ones_c;

    logic_sweep #(.WIDTH(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef LOGIC_SWEEP_HOLD_EN
        .hold(hold),
`endif
        .busy(busy_a), .valid(valid_a), .vec(vec_a), .s(s_a), .ones_cnt(ones_a), .done(done_a)
    );
    logic_sweep #(.WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef LOGIC_SWEEP_HOLD_EN
        .hold(hold),
`endif
        .busy(busy_b), .valid(valid_b), .vec(vec_b), .s(s_b), .ones_cnt(ones_b), .done(done_b)
    );
    logic_sweep #(.WIDTH(3)) dut_c (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
`ifdef LOGIC_SWEEP_HOLD_EN
        .hold(hold),
`endif
        .busy(busy_c), .valid(valid_c), .vec(vec_c), .s(s_c), .ones_cnt(ones_c), .done(done_c)
    );

    typedef struct {
        int vec;
        bit s;
        int ones;
        int rel;
        bit is_done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference gate: stated directly in terms of row index and popcount.
    function automatic bit model_s(input int w, input int m, input int r);
        int full;
        int pc;
        full = (1 << w) - 1;
        pc   = $countones(r);
        case (m)
            0:       return r == 0;
            1:       return r != full;
            2:       return r == full;
            3:       return r != 0;
            4:       return (pc % 2) == 1;
            5:       return (pc % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push_exp(input int inst, input int w, input int m, input int hold_row, input int hold_len);
        exp_t e;
        int   ones;
        ones = 0;
        for (int r = 0; r < (1 << w); r++) begin
            e.vec     = r;
            e.s       = model_s(w, m, r);
            e.ones    = ones;
            e.rel     = r + 1 + ((r > hold_row) ? hold_len : 0);
            e.is_done = 1'b0;
            if (inst == 0) q0.push_back(e); else if (inst == 1) q1.push_back(e); else q2.push_back(e);
            ones += int'(e.s);
        end
        e.vec     = 0;
        e.s       = 1'b0;
        e.ones    = ones;
        e.rel     = (1 << w) + 1 + hold_len;
        e.is_done = 1'b1;
        if (inst == 0) q0.push_back(e); else if (inst == 1) q1.push_back(e); else q2.push_back(e);
    endtask

    function automatic int q_size(input int inst);
        if (inst == 0) return q0.size();
        if (inst == 1) return q1.size();
        return q2.size();
    endfunction

    function automatic exp_t q_pop(input int inst);
        if (inst == 0) return q0.pop_front();
        if (inst == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    task automatic mon_step(input int inst, input logic vld, input int v, input logic sv,
                            input int ones, input logic dn, input logic bsy);
        exp_t e;
        int   rel;
        rel = cyc - start_cyc;
        if (vld === 1'b1 || dn === 1'b1) begin
            if (q_size(inst) == 0) begin
                checks++;
                failures++;
                $display("FAIL i%0d_unexpected_output actual=valid%0b_done%0b required=nothing", inst, vld, dn);
            end else begin
                e = q_pop(inst);
                chk($sformatf("i%0d_kind_is_done", inst), int'(dn), int'(e.is_done));
                chk($sformatf("i%0d_ones_cnt", inst), ones, e.ones);
                chk($sformatf("i%0d_cycle", inst), rel, e.rel);
                if (e.is_done) begin
                    chk($sformatf("i%0d_valid_in_done", inst), int'(vld), 0);
                    chk($sformatf("i%0d_busy_in_done", inst), int'(bsy), 0);
                end else begin
                    chk($sformatf("i%0d_vec", inst), v, e.vec);
                    chk($sformatf("i%0d_s", inst), int'(sv), int'(e.s));
                    chk($sformatf("i%0d_busy_in_run", inst), int'(bsy), 1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, valid_a, int'(vec_a), s_a, int'(ones_a), done_a, busy_a);
        mon_step(1, valid_b, int'(vec_b), s_b, int'(ones_b), done_b, busy_b);
        mon_step(2, valid_c, int'(vec_c), s_c, int'(ones_c), done_c, busy_c);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, int'({busy_a, valid_a, vec_a, s_a, ones_a, done_a}), 0);
        chk({tag, "_b"}, int'({busy_b, valid_b, vec_b, s_b, ones_b, done_b}), 0);
        chk({tag, "_c"}, int'({busy_c, valid_c, vec_c, s_c, ones_c, done_c}), 0);
    endtask

    task automatic sweep(input int m, input int hold_row, input int hold_len,
                         input int repulse_rel, input int reset_rel);
        bit finished;
        finished = 1'b0;
        @(negedge clk); #1;
        push_exp(0, 1, m, hold_row, hold_len);
        push_exp(1, 2, m, hold_row, hold_len);
        push_exp(2, 3, m, hold_row, hold_len);
        mode      = 3'(m);
        start     = 1'b1;
        start_cyc = cyc;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk); #1;
            start = (k == repulse_rel);
            mode  = (k == repulse_rel) ? 3'b011 : 3'($urandom_range(0, 7));
`ifdef LOGIC_SWEEP_HOLD_EN
            hold = (hold_len > 0) && (k >= hold_row + 1) && (k < hold_row + 1 + hold_len);
`endif
            if (reset_rel > 0 && k == reset_rel) reset = 1'b1;
            if (reset_rel > 0 && k == reset_rel + 1) begin
                chk_all_zero("outputs_after_reset");
                q0.delete(); q1.delete(); q2.delete();
                reset    = 1'b0;
                finished = 1'b1;
                break;
            end
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
`ifdef LOGIC_SWEEP_HOLD_EN
        hold = 1'b0;
`endif
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout actual=pending%0d_%0d_%0d required=0", q0.size(), q1.size(), q2.size());
            q0.delete(); q1.delete(); q2.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset_state");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        sweep(0, 0, 0, 0, 0);   // NOR
        sweep(1, 0, 0, 0, 0);   // NAND
        sweep(4, 0, 0, 0, 0);   // XOR
        sweep(7, 0, 0, 0, 0);   // reserved
        sweep(5, 0, 0, 0, 0);   // XNOR
        sweep(2, 0, 0, 0, 0);   // AND
        sweep(3, 0, 0, 0, 0);   // OR
        sweep(0, 0, 0, 3, 0);   // re-start pulse plus mode change mid-run
        sweep(0, 0, 0, 0, 3);   // reset while row 2 is shown
        repeat (12) @(negedge clk);
`ifdef LOGIC_SWEEP_HOLD_EN
        sweep(0, 1, 3, 0, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            int gap;
            int hrow;
            int hlen;
            gap  = $urandom_range(0, 3);
            hrow = $urandom_range(0, 1);
            hlen = 0;
`ifdef LOGIC_SWEEP_HOLD_EN
            hlen = $urandom_range(0, 3);
`endif
            repeat (gap) @(negedge clk);
            sweep($urandom_range(0, 7), hrow, hlen, $urandom_range(0, 3), 0);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("idle_busy_c", int'(busy_c), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_sweep.md
LOGIC_SWEEP -- requirements
Module: logic_sweep

Interface
- REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
- REQ-002 Parameter: WIDTH, default 2, the number of gate inputs, legal range 1..8.
- REQ-003 clk  input  1  rising-edge clock for all state.
- REQ-004 reset  input  1  synchronous active-high reset.
- REQ-005 start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
- REQ-006 mode  input  3  gate selection, latched at start: 000 NOR, 001 NAND, 010 AND, 011 OR, 100 XOR, 101 XNOR; 110/111 reserved.
- REQ-007 busy  output  1  high in RUN.
- REQ-008 valid  output  1  high when vec/s carry a fresh truth-table row.
- REQ-009 vec  output  WIDTH  current input combination (minterm index).
- REQ-010 s  output  1  gate result for vec under the latched mode.
- REQ-011 ones_cnt  output  WIDTH+1  count of rows with s=1 in the current/last sweep.
- REQ-012 done  output  1  single-cycle pulse after the last row.

Function
- REQ-013 FSM states SHALL be IDLE, RUN and DONE.
- REQ-014 IDLE->RUN on start=1; RUN->DONE after row 2^WIDTH-1 is presented; DONE->IDLE unconditionally after 1 cycle.
- REQ-015 The cycle after start is sampled: vec=0, valid=1, busy=1, s=f(0), ones_cnt=0; latency from start to first row is 1 cycle.
- REQ-016 Each RUN cycle presents exactly one row; vec increments by 1 per cycle; s and vec are registered together and are never skewed.
- REQ-017 ones_cnt SHALL increment, in the cycle after each row is presented, when that row has s=1; the final value is correct in DONE and held until the next start.
- REQ-018 vec SHALL NOT wrap: after 2^WIDTH-1 the FSM enters DONE with valid=0; vec holds its last value.
- REQ-019 A full sweep SHALL take exactly 2^WIDTH RUN cycles plus 1 DONE cycle.
- REQ-020 start in RUN or DONE SHALL be ignored; mode changes after latching SHALL have no effect until the next sweep.
- REQ-021 Reserved mode SHALL give s=0 for every row, ones_cnt=0, with normal sequencing.
- REQ-022 WIDTH=1: NOR/NAND reduce to NOT, AND/OR to buffer, XOR/XNOR to buffer/NOT.

Reset
- REQ-023 Reset SHALL force IDLE and set busy=0, valid=0, done=0, s=0, vec=0, ones_cnt=0 and latched mode=000.
- REQ-024 Reset SHALL take priority over start and hold, including mid-sweep, with no done pulse.

Configuration
- REQ-025 With LOGIC_SWEEP_HOLD_EN defined, a port hold (input, 1) SHALL exist: while hold=1 in RUN, vec, s and ones_cnt freeze and valid=0; the sweep resumes at the next row when hold drops; hold has no effect in IDLE or DONE.
- REQ-026 Without LOGIC_SWEEP_HOLD_EN, no hold port SHALL exist and RUN advances every cycle.

Structure
- REQ-027 Package logic_sweep_pkg SHALL hold the mode encodings (MODE_NOR..MODE_XNOR) and the state enumeration.
- REQ-028 Sub-module logic_eval (combinational, parameter WIDTH, inputs mode and vec, output s) SHALL compute the gate; logic_sweep SHALL instantiate it once.

Verification
- REQ-029 WIDTH=2, mode=NOR, start pulse -> vec 0,1,2,3 with s 1,0,0,0; ones_cnt=1; done at cycle 5 after start.
- REQ-030 WIDTH=2, mode=NAND -> s 1,1,1,0, ones_cnt=3; WIDTH=3, mode=XOR -> s 0,1,1,0,1,0,0,1, ones_cnt=4.
- REQ-031 WIDTH=2, NOR sweep; reset asserted at row 2 -> next cycle IDLE, all outputs 0, no done pulse.
- REQ-032 WIDTH=2, start re-pulsed and mode changed to OR during RUN -> sweep continues unchanged as NOR; exactly one done.
- REQ-033 Mode=111, WIDTH=3 -> 8 rows with s=0, ones_cnt=0, done pulse at cycle 9.
- REQ-034 With LOGIC_SWEEP_HOLD_EN, WIDTH=2, NOR, hold=1 for 3 cycles at row 1 -> valid=0 and vec=1 frozen; then rows 2,3; done at cycle 8.
